shared_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle shared unit (a single start/done datapath instance) among `N` requesters. It picks one requester, drives the unit's select index, and issues a one-cycle start pulse. It then holds the grant until the unit reports done and releases it before arbitrating again. It sits between the requesting blocks and the shared instance inside the enclosing module.

---
 rtl/shared_unit_arbiter.sv | 92 +++++++++
 tb/tb_shared_unit_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/shared_unit_arbiter.sv
// shared_unit_arbiter: round-robin arbiter/sequencer sharing one start/done unit among N requesters
// Ports: clk, reset (async active-low), req[N], gnt[N] one-hot, unit_sel[IW], unit_start pulse,
//        unit_done, busy (START/BUSY/RELEASE), timeout pulse on forced release.
// Optional watchdog: define SHARED_UNIT_ARBITER_TIMEOUT_EN to release BUSY after TIMEOUT cycles.
module shared_unit_arbiter #(
  parameter int N = 4,
  parameter int IW = 2,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] unit_sel,
  output logic          unit_start,
  input  logic          unit_done,
  output logic          busy,
  output logic          timeout
);
  typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} state_t;
  state_t state;
  logic [IW-1:0] ptr, win, idx;
  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      win = req[idx] ? idx : win;
    end
  end
`ifdef SHARED_UNIT_ARBITER_TIMEOUT_EN
  logic [7:0] cnt;
`else
  // No watchdog is built; the comparison is constant 0 over the legal TIMEOUT range.
  assign timeout = (TIMEOUT < 0);
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      unit_sel   <= '0;
      unit_start <= 1'b0;
      busy       <= 1'b0;
`ifdef SHARED_UNIT_ARBITER_TIMEOUT_EN
      cnt        <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      unit_start <= 1'b0;
`ifdef SHARED_UNIT_ARBITER_TIMEOUT_EN
      timeout    <= 1'b0;
`endif
      case (state)
        IDLE: if (|req) begin
          state      <= START;
          gnt        <= N'(1) << win;
          unit_sel   <= win;
          ptr        <= IW'((int'(win) + 1) % N);
          unit_start <= 1'b1;
          busy       <= 1'b1;
        end
        START: begin
          state <= BUSY;
`ifdef SHARED_UNIT_ARBITER_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        BUSY: begin
`ifdef SHARED_UNIT_ARBITER_TIMEOUT_EN
          cnt <= cnt + 8'd1;
          if (unit_done || cnt == 8'(TIMEOUT - 1)) begin
            state   <= RELEASE;
            gnt     <= '0;
            timeout <= !unit_done;
          end
`else
          if (unit_done) begin
            state <= RELEASE;
            gnt   <= '0;
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shared_unit_arbiter.sv
// tb_shared_unit_arbiter: randomized transaction-level check of shared_unit_arbiter against a round-robin model
module tb_shared_unit_arbiter;
  localparam int TO = 16;
`ifdef SHARED_UNIT_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, unit_done = 1'b0;
  logic [3:0] req = 4'd0, gnt;
  logic [1:0] unit_sel;
  logic unit_start, busy, timeout;
  int n_chk = 0, n_fail = 0, ptr_m = 0, sel_m = 0, cyc = 0, last_g = 0;
  shared_unit_arbiter #(.N(4), .IW(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .unit_sel(unit_sel),
    .unit_start(unit_start), .unit_done(unit_done), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h ({gnt,sel,start,busy,timeout})", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] obs();
    return {gnt, unit_sel, unit_start, busy, timeout};
  endfunction
  function automatic logic [8:0] ex(input int g, input int s, input int st, input int b, input int to);
    return {4'(g), 2'(s), 1'(st), 1'(b), 1'(to)};
  endfunction
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // One arbitration from IDLE; done_after = BUSY cycle on which unit_done is raised.
  task automatic txn(input logic [3:0] r, input int done_after);
    int w, rel, to;
    req = r;
    w = pick(r, ptr_m);
    tick();
    if (w < 0) begin
      check("idle_noreq", obs(), ex(0, sel_m, 0, 0, 0));
      return;
    end
    last_g = cyc;
    check("grant", obs(), ex(1 << w, w, 1, 1, 0));
    ptr_m = (w + 1) % 4;
    sel_m = w;
    to = (TO_EN && done_after > TO) ? 1 : 0;
    rel = to ? TO : done_after;
    req = 4'($urandom);
    tick();
    check("busy_entry", obs(), ex(1 << w, w, 0, 1, 0));
    for (int j = 1; j <= rel; j++) begin
      unit_done = (j == done_after);
      req = 4'($urandom);
      tick();
      unit_done = 1'b0;
      if (j < rel) check("busy_hold", obs(), ex(1 << w, w, 0, 1, 0));
    end
    check("release", obs(), ex(0, w, 0, 1, to));
    tick();
    check("back_idle", obs(), ex(0, w, 0, 0, 0));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int prev;
    #12;
    check("reset_async", obs(), 9'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_idle", obs(), 9'd0);
    end
    for (int i = 0; i < 5; i++) begin
      prev = last_g;
      txn(4'b1111, 1);
      check("fair_order", 9'(sel_m), 9'(i % 4));
      if (i > 0) check("fair_spacing", 9'(last_g - prev), 9'd4);
    end
    txn(4'b0100, 3);
    check("single_ptr", 9'(ptr_m), 9'd3);
    txn(4'b0101, 1);
    check("wrap_first", 9'(sel_m), 9'd0);
    txn(4'b0101, 2);
    check("skip_second", 9'(sel_m), 9'd2);
    txn(4'b0010, TO_EN ? 40 : 101);
    if (TO_EN) txn(4'b0010, TO);
    req = 4'b0100;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", obs(), 9'd0);
    req = 4'b0000;
    tick();
    check("rst_hold", obs(), 9'd0);
    reset = 1'b1;
    ptr_m = 0;
    sel_m = 0;
    tick();
    check("rst_no_replay", obs(), 9'd0);
    txn(4'b1111, 1);
    check("rst_ptr", 9'(sel_m), 9'd0);
    txn(4'b0100, 2);
    for (int i = 0; i < 40; i++) txn(4'($urandom), int'($urandom_range(1, 5)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
